wb_ram_arbiter: RTL
===================

# wb_ram_arbiter

Two-master Wishbone arbiter that shares the single base-RAM slave port (`RAMSlave`) between the CPU instruction-fetch master (m0) and data master (m1). It sits between `SystemOnCat`'s memory masters and `RAMSlave` on the `clk_bus` domain. It supports pipelined Wishbone with stall, tracks outstanding requests, and issues a watchdog error if the slave stops responding.

## Interface
- `MAX_OUT`, 3: maximum accepted-but-unanswered requests; range 1–15.
- `TIMEOUT`, 255: cycles without a slave response, while requests are outstanding, before a forced error; range 2–65535.

Ports:
- `clk_bus` input 1: bus clock; all logic on rising edge.
- `rst_bus` input 1: asynchronous, active-low reset.
- `mN_adr_i` input 32: master N address (N = 0, 1); same pattern for the next four lines.
- `mN_dat_i` input 32: master N write data.
- `mN_sel_i` input 4: master N byte select.
- `mN_cyc_i`, `mN_stb_i`, `mN_we_i` input 1 each: master N Wishbone cycle, strobe and write enable.
- `mN_dat_o` output 32: read data to master N.
- `mN_ack_o`, `mN_err_o`, `mN_rty_o`, `mN_stall_o` output 1 each: responses and stall to master N.
- `s_adr_o` output 32, `s_dat_o` output 32, `s_sel_o` output 4: to the slave.
- `s_cyc_o`, `s_stb_o`, `s_we_o` output 1 each: to the slave.
- `s_dat_i` input 32: read data from the slave.
- `s_ack_i`, `s_err_i`, `s_rty_i`, `s_stall_i` input 1 each: slave responses and stall.

## Operation
**State machine**
- States: IDLE, GNT0, GNT1.
- IDLE: if any `mN_cyc_i` is high, go to GNTn of the arbitration winner next cycle.
- GNTn held while `mn_cyc_i` = 1.
- On `mn_cyc_i` = 0 or timeout:
  - go to the other GNT if that master's `cyc_i` = 1;
  - otherwise go to IDLE.

**Routing (combinational from state)**
- GNTn: `s_*` outputs = master n inputs, except that `s_stb_o` is forced 0 when `out_cnt` == `MAX_OUT`.
- GNTn: `mn_stall_o` = `s_stall_i` OR (`out_cnt` == `MAX_OUT`).
- GNTn: `mn_ack_o`/`err_o`/`rty_o` = slave responses; `mn_dat_o` = `s_dat_i`.
- Non-granted master: stall = 1; ack/err/rty = 0; `dat_o` = 0.
- IDLE: all `s_*` outputs = 0; both stalls = 1.

**Outstanding counter `out_cnt` (4 bit)**
- Accept = `s_stb_o` & !`s_stall_i` → +1.
- Response = `s_ack_i` | `s_err_i` | `s_rty_i` → −1.
- Accept and response in the same cycle → unchanged.
- A response arriving with `out_cnt` = 0 is dropped, not routed, and the counter does not underflow.
- Cleared on leaving a GNT state. A master dropping cyc mid-burst is a Wishbone abort: `s_cyc_o` falls the same cycle and late responses are discarded.

**Watchdog `wd_cnt` (16 bit)**
- Increments each cycle in GNTn with `out_cnt` > 0 and no response.
- Cleared by any response or accept, and on state change.
- When `wd_cnt` == `TIMEOUT - 1`:
  - `mn_err_o` = 1 for that one cycle;
  - `s_cyc_o` is forced 0 that cycle;
  - `out_cnt` and `wd_cnt` are cleared;
  - the state transitions as for cyc release.

**Arbitration**
- Arbitration policy is set by `ARB_ROUND_ROBIN_EN`; see Configuration.
- `last` register: the most recently granted master, updated on each entry into a GNT state.

## Timing
- Reset values:
  - state = IDLE; `out_cnt` = 0; `wd_cnt` = 0; `last` = 1;
  - all `s_*` outputs = 0;
  - `mN_stall_o` = 1; `mN_ack_o` = `mN_err_o` = `mN_rty_o` = 0; `mN_dat_o` = 0.
- Reset takes effect asynchronously, including mid-transaction. Release is synchronous: the first edge with `rst_bus` high evaluates IDLE.
- Grant latency: 1 cycle from `cyc_i` rising in IDLE to GNT, then zero added latency on the request and response paths.
- Handoff: zero idle cycles when the other master is already waiting.
- Master must hold its request while stalled (standard pipelined Wishbone).

## Configuration
- `ARB_ROUND_ROBIN_EN` defined: on simultaneous requests, the master ≠ `last` wins.
- Undefined: fixed priority; m1 (data) always wins ties, and m0 waits until m1 drops cyc.
- With a single requester, both modes grant it.

## Test plan
1. **Single m0 read.** m0 cyc/stb to 0x80000000 with a 1-cycle slave ack and data 0xDEADBEEF:
   - GNT0 one cycle later;
   - `s_adr_o` = 0x80000000;
   - `m0_dat_o` = 0xDEADBEEF with `m0_ack_o` = 1;
   - m1 outputs stay at stall = 1, ack = 0.
2. **Simultaneous request after reset.**
   - With the macro: m0 is granted first; after m0 drops cyc, m1 is granted in the same edge.
   - Without the macro: m1 is granted first.
3. **Outstanding limit.** `MAX_OUT` = 3; m1 issues 4 strobes; slave stall = 0 and acks are withheld:
   - 3 accepts;
   - 4th strobe sees `m1_stall_o` = 1 and `s_stb_o` = 0 until the first ack;
   - the 4th request is accepted in the ack cycle.
4. **Watchdog.** `TIMEOUT` = 16; one accepted strobe; slave silent:
   - `m0_err_o` pulses exactly 16 cycles after the accept;
   - `s_cyc_o` is 0 that cycle; `out_cnt` = 0 next cycle.
5. **Reset mid-transaction.** Assert `rst_bus` low between a clock edge during GNT1 with 2 requests outstanding:
   - outputs go to reset values immediately, without a clock edge;
   - after release, a late `s_ack_i` is not routed to either master.
6. **Abort.** m0 drops cyc with `out_cnt` = 2:
   - `s_cyc_o` falls the same cycle;
   - a subsequent `s_ack_i` produces no `m0_ack_o`;
   - the FSM goes to IDLE, or to GNT1 if m1 is waiting.

Source files
------------

// File: rtl/wb_ram_arbiter.sv
// wb_ram_arbiter: two-master pipelined Wishbone arbiter for the base-RAM slave; `define ARB_ROUND_ROBIN_EN for round-robin ties, otherwise m1 wins ties
module wb_ram_arbiter #(
  parameter int MAX_OUT = 3,
  parameter int TIMEOUT = 255
) (
  input  logic        clk_bus,
  input  logic        rst_bus,
  input  logic [31:0] m0_adr_i,
  input  logic [31:0] m0_dat_i,
  input  logic [3:0]  m0_sel_i,
  input  logic        m0_cyc_i,
  input  logic        m0_stb_i,
  input  logic        m0_we_i,
  output logic [31:0] m0_dat_o,
  output logic        m0_ack_o,
  output logic        m0_err_o,
  output logic        m0_rty_o,
  output logic        m0_stall_o,
  input  logic [31:0] m1_adr_i,
  input  logic [31:0] m1_dat_i,
  input  logic [3:0]  m1_sel_i,
  input  logic        m1_cyc_i,
  input  logic        m1_stb_i,
  input  logic        m1_we_i,
  output logic [31:0] m1_dat_o,
  output logic        m1_ack_o,
  output logic        m1_err_o,
  output logic        m1_rty_o,
  output logic        m1_stall_o,
  output logic [31:0] s_adr_o,
  output logic [31:0] s_dat_o,
  output logic [3:0]  s_sel_o,
  output logic        s_cyc_o,
  output logic        s_stb_o,
  output logic        s_we_o,
  input  logic [31:0] s_dat_i,
  input  logic        s_ack_i,
  input  logic        s_err_i,
  input  logic        s_rty_i,
  input  logic        s_stall_i
);
  typedef enum logic [1:0] {IDLE, GNT0, GNT1} state_t;
  state_t state, state_nx;
  logic [3:0] out_cnt;
  logic [15:0] wd_cnt;
  logic last, g0, g1, gnt, cyc, stb, any_rsp, rsp, full, to, acc, win1;
  assign g0 = state == GNT0;
  assign g1 = state == GNT1;
  assign gnt = g0 | g1;
  assign cyc = g1 ? m1_cyc_i : g0 ? m0_cyc_i : 1'b0;
  assign stb = g1 ? m1_stb_i : g0 ? m0_stb_i : 1'b0;
  assign any_rsp = s_ack_i | s_err_i | s_rty_i;
  assign to = gnt && wd_cnt == 16'(TIMEOUT - 1);
  // responses with nothing outstanding (e.g. after an abort) are stray and dropped
  assign rsp = gnt && out_cnt != 4'd0 && any_rsp && !to;
  // a response in the same cycle frees a slot, so a full pipeline can still accept
  assign full = out_cnt == 4'(MAX_OUT) && !rsp;
  assign s_cyc_o = cyc & ~to;
  assign s_stb_o = stb & cyc & ~full & ~to;
  assign s_we_o = g1 ? m1_we_i : g0 ? m0_we_i : 1'b0;
  assign s_adr_o = g1 ? m1_adr_i : g0 ? m0_adr_i : 32'h0;
  assign s_dat_o = g1 ? m1_dat_i : g0 ? m0_dat_i : 32'h0;
  assign s_sel_o = g1 ? m1_sel_i : g0 ? m0_sel_i : 4'h0;
  assign acc = s_stb_o & ~s_stall_i;
  assign m0_stall_o = g0 ? (s_stall_i | full) : 1'b1;
  assign m1_stall_o = g1 ? (s_stall_i | full) : 1'b1;
  assign m0_ack_o = g0 & rsp & s_ack_i;
  assign m1_ack_o = g1 & rsp & s_ack_i;
  assign m0_err_o = g0 & ((rsp & s_err_i) | to);
  assign m1_err_o = g1 & ((rsp & s_err_i) | to);
  assign m0_rty_o = g0 & rsp & s_rty_i;
  assign m1_rty_o = g1 & rsp & s_rty_i;
  assign m0_dat_o = g0 ? s_dat_i : 32'h0;
  assign m1_dat_o = g1 ? s_dat_i : 32'h0;
`ifdef ARB_ROUND_ROBIN_EN
  assign win1 = m1_cyc_i & (~m0_cyc_i | ~last);
`else
  assign win1 = m1_cyc_i;
`endif
  // next grant: arbitrate from IDLE, hand off to the other master on release or timeout
  always_comb begin
    state_nx = state;
    if (state == IDLE)
      state_nx = win1 ? GNT1 : m0_cyc_i ? GNT0 : IDLE;
    else if (g0 && (!m0_cyc_i || to))
      state_nx = m1_cyc_i ? GNT1 : IDLE;
    else if (g1 && (!m1_cyc_i || to))
      state_nx = m0_cyc_i ? GNT0 : IDLE;
  end
  // grant state, outstanding count and watchdog; all bookkeeping restarts on a grant change
  always_ff @(posedge clk_bus or negedge rst_bus) begin
    if (!rst_bus) begin
      state <= IDLE;
      out_cnt <= 4'd0;
      wd_cnt <= 16'd0;
      last <= 1'b1;
    end else begin
      state <= state_nx;
      if (state_nx != state && state_nx != IDLE) last <= state_nx == GNT1;
      out_cnt <= (state_nx != state || to) ? 4'd0 : out_cnt + 4'(acc) - 4'(rsp);
      wd_cnt <= (state_nx != state || to || acc || any_rsp || !gnt || out_cnt == 4'd0) ? 16'd0 : wd_cnt + 16'd1;
    end
  end
endmodule
